// File: rtl/ysyx_redirect_seq.sv
// Commit-side redirect sequencer: store-queue drain, I-cache invalidate, flush.
// Optional perf counters enabled with YSYX_REDIRECT_PERF_EN.
module ysyx_redirect_seq #(
  parameter int XLEN          = 32,
  parameter int DRAIN_TIMEOUT = 64,
  parameter int CNT_W         = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cm_valid,
  input  logic [2:0]      cm_kind,
  input  logic [XLEN-1:0] cm_target,
  output logic            cm_ready,
  input  logic            sq_empty,
  output logic            ic_inv_req,
  input  logic            ic_inv_ack,
  output logic            flush_pipeline,
  output logic            fence_time,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy,
  output logic            drain_err
`ifdef YSYX_REDIRECT_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_brmiss,
  output logic [CNT_W-1:0] perf_fence,
  output logic [CNT_W-1:0] perf_drain_cycles
`endif
);

  localparam logic [2:0] K_BR   = 3'd1;
  localparam logic [2:0] K_TRAP = 3'd2;
  localparam logic [2:0] K_MRET = 3'd3;
  localparam logic [2:0] K_FI   = 3'd4;
  localparam logic [2:0] K_FT   = 3'd5;

  localparam int CW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DRAIN_TIMEOUT);
  localparam logic [CW-1:0] CNT_ERR = CW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    INV,
    FLUSH
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      kind_q;
  logic [XLEN-1:0] target_q;

  logic is_jmp;
  logic is_fence;

  assign is_jmp   = cm_kind inside {K_BR, K_TRAP, K_MRET};
  assign is_fence = cm_kind inside {K_FI, K_FT};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      kind_q    <= '0;
      target_q  <= '0;
      drain_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cm_valid) begin
            unique case (1'b1)
              is_jmp: begin
                state    <= FLUSH;
                kind_q   <= cm_kind;
                target_q <= cm_target;
              end
              is_fence: begin
                state    <= DRAIN;
                cnt      <= '0;
                kind_q   <= cm_kind;
                target_q <= cm_target;
              end
              default: ;
            endcase
          end
        end
        DRAIN: begin
          if (sq_empty) begin
            cnt   <= '0;
            state <= (kind_q == K_FI) ? INV : FLUSH;
          end else begin
            if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
            // sticky: keep waiting, just flag it
            if (cnt >= CNT_ERR) drain_err <= 1'b1;
          end
        end
        INV: begin
          if (ic_inv_ack) state <= FLUSH;
        end
        FLUSH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cm_ready       = (state == IDLE);
  assign busy           = (state != IDLE);
  assign ic_inv_req     = (state == INV);
  assign flush_pipeline = (state == FLUSH);
  assign redirect_valid = (state == FLUSH);
  assign fence_time     = (state == FLUSH) && (kind_q == K_FT);
  assign redirect_pc    = target_q;

`ifdef YSYX_REDIRECT_PERF_EN
  logic acc;
  assign acc = cm_valid && (state == IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_brmiss       <= '0;
      perf_fence        <= '0;
      perf_drain_cycles <= '0;
    end else begin
      if (acc && cm_kind == K_BR)
        perf_brmiss <= perf_brmiss + CNT_W'(1);
      if (acc && is_fence)
        perf_fence <= perf_fence + CNT_W'(1);
      if (state == DRAIN)
        perf_drain_cycles <= perf_drain_cycles + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_redirect_seq.sv
// Scoreboard bench for ysyx_redirect_seq: driver pushes expected redirects,
// a negedge monitor pops and compares. Honours YSYX_REDIRECT_PERF_EN.
module tb_ysyx_redirect_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        cm_valid;
  logic [2:0]  cm_kind;
  logic [31:0] cm_target;
  logic        cm_ready;
  logic        sq_empty;
  logic        ic_inv_req;
  logic        ic_inv_ack;
  logic        flush_pipeline;
  logic        fence_time;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  logic        drain_err;
`ifdef YSYX_REDIRECT_PERF_EN
  logic [15:0] perf_brmiss;
  logic [15:0] perf_fence;
  logic [15:0] perf_drain_cycles;
`endif

  ysyx_redirect_seq dut (
    .clock          (clock),
    .reset          (reset),
    .cm_valid       (cm_valid),
    .cm_kind        (cm_kind),
    .cm_target      (cm_target),
    .cm_ready       (cm_ready),
    .sq_empty       (sq_empty),
    .ic_inv_req     (ic_inv_req),
    .ic_inv_ack     (ic_inv_ack),
    .flush_pipeline (flush_pipeline),
    .fence_time     (fence_time),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy),
    .drain_err      (drain_err)
`ifdef YSYX_REDIRECT_PERF_EN
    ,
    .perf_brmiss       (perf_brmiss),
    .perf_fence        (perf_fence),
    .perf_drain_cycles (perf_drain_cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic        ft;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  // model of what the sequencer should be showing this cycle
  logic        mon_en = 1'b0;
  logic        exp_ready = 1'b1;
  logic        exp_inv = 1'b0;
  logic        exp_flush = 1'b0;
  logic        exp_derr = 1'b0;
  logic [31:0] exp_pc = '0;
  int          m_br = 0;
  int          m_fence = 0;
  int          m_drain = 0;
  logic        noise_trap = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      chk("cm_ready", 32'(cm_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(!exp_ready));
      chk("ic_inv_req", 32'(ic_inv_req), 32'(exp_inv));
      chk("flush", 32'(flush_pipeline), 32'(exp_flush));
      chk("redirect_valid", 32'(redirect_valid), 32'(exp_flush));
      chk("drain_err", 32'(drain_err), 32'(exp_derr));
      chk("redirect_pc_hold", redirect_pc, exp_pc);
      if (redirect_valid) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_redirect", 32'(redirect_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("redirect_pc", redirect_pc, e.pc);
          chk("fence_time", 32'(fence_time), 32'(e.ft));
        end
      end else begin
        chk("fence_time_idle", 32'(fence_time), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic noise();
    cm_valid   = noise_trap ? 1'b1 : 1'($urandom);
    cm_kind    = noise_trap ? 3'd2 : 3'($urandom);
    cm_target  = $urandom;
    ic_inv_ack = 1'($urandom);
  endtask

  task automatic quiet();
    cm_valid   = 1'b0;
    cm_kind    = 3'($urandom);
    cm_target  = $urandom;
    sq_empty   = 1'($urandom);
    ic_inv_ack = 1'($urandom);
  endtask

  // one redirect event; d = cycles sq_empty stays low, a = INV cycles before ack
  task automatic txn(input logic [2:0] k, input logic [31:0] t,
                     input int d, input int a);
    exp_t e;
    cm_valid   = 1'b1;
    cm_kind    = k;
    cm_target  = t;
    sq_empty   = 1'($urandom);
    ic_inv_ack = 1'($urandom);
    tick();
    e.pc   = t;
    e.ft   = (k == 3'd5);
    sb.push_back(e);
    exp_pc    = t;
    exp_ready = 1'b0;
    if (k == 3'd1) m_br++;
    if (k >= 3'd4) begin
      m_fence++;
      for (int i = 0; i <= d; i++) begin
        if (d >= 64 && i >= 64) exp_derr = 1'b1;
        noise();
        sq_empty = (i >= d);
        m_drain++;
        tick();
      end
      if (k == 3'd4) begin
        exp_inv = 1'b1;
        for (int j = 0; j <= a; j++) begin
          noise();
          sq_empty   = 1'($urandom);
          ic_inv_ack = (j == a);
          tick();
        end
        exp_inv = 1'b0;
      end
    end
    exp_flush = 1'b1;
    noise();
    sq_empty = 1'($urandom);
    tick();
    exp_flush = 1'b0;
    exp_ready = 1'b1;
    quiet();
  endtask

  task automatic idle_noise();
    logic [2:0] bad[3];
    bad[0] = 3'd0;
    bad[1] = 3'd6;
    bad[2] = 3'd7;
    if ($urandom_range(0, 1) == 0) begin
      cm_valid = 1'b1;
      cm_kind  = bad[$urandom_range(0, 2)];
    end else begin
      cm_valid = 1'b0;
      cm_kind  = 3'($urandom_range(1, 5));
    end
    cm_target = $urandom;
    tick();
    quiet();
  endtask

  task automatic chk_perf();
`ifdef YSYX_REDIRECT_PERF_EN
    chk("perf_brmiss", 32'(perf_brmiss), 32'(m_br % 65536));
    chk("perf_fence", 32'(perf_fence), 32'(m_fence % 65536));
    chk("perf_drain", 32'(perf_drain_cycles), 32'(m_drain % 65536));
`endif
  endtask

  initial begin
    logic [2:0] k;
    reset = 1'b0;
    quiet();
    repeat (3) @(posedge clock);
    #3;
    chk("rst_cm_ready", 32'(cm_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pc", redirect_pc, 32'd0);
    chk_perf();
    reset  = 1'b1;
    mon_en = 1'b1;

    txn(3'd1, 32'h8000_0100, 0, 0);
    idle_noise();
    txn(3'd4, 32'h8000_0200, 3, 2);
    txn(3'd5, 32'h8000_0300, 0, 0);
    noise_trap = 1'b1;
    txn(3'd4, 32'h8000_0400, 1, 3);
    noise_trap = 1'b0;
    idle_noise();
    idle_noise();
    txn(3'd5, 32'h8000_0500, 70, 0);
    chk_perf();

    // asynchronous reset in the middle of INV
    cm_valid  = 1'b1;
    cm_kind   = 3'd4;
    cm_target = 32'h8000_0600;
    tick();
    exp_pc = 32'h8000_0600;
    exp_ready = 1'b0;
    m_fence++;
    sb.push_back('{pc: 32'h8000_0600, ft: 1'b0});
    cm_valid = 1'b0;
    sq_empty = 1'b1;
    m_drain++;
    tick();
    exp_inv = 1'b1;
    ic_inv_ack = 1'b0;
    sq_empty   = 1'b0;
    tick();
    chk("pre_rst_inv", 32'(ic_inv_req), 32'd1);
    #1;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk("arst_inv", 32'(ic_inv_req), 32'd0);
    chk("arst_flush", 32'(flush_pipeline), 32'd0);
    chk("arst_rv", 32'(redirect_valid), 32'd0);
    chk("arst_ft", 32'(fence_time), 32'd0);
    chk("arst_pc", redirect_pc, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_derr", 32'(drain_err), 32'd0);
    chk("arst_ready", 32'(cm_ready), 32'd1);
    sb.delete();
    exp_inv = 1'b0; exp_flush = 1'b0; exp_ready = 1'b1;
    exp_derr = 1'b0; exp_pc = '0;
    m_br = 0; m_fence = 0; m_drain = 0;
    chk_perf();
    repeat (2) @(posedge clock);
    #3;
    reset  = 1'b1;
    mon_en = 1'b1;
    quiet();
    tick();

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) idle_noise();
      k = 3'($urandom_range(1, 5));
      txn(k, $urandom, $urandom_range(0, 6), $urandom_range(0, 4));
    end

    tick();
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk_perf();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_redirect_seq.md
Name: ysyx_redirect_seq

Overview:
- Commit-side redirect sequencer between the ROB head and the frontend, store queue and I-cache.
- Accepts one redirect-class commit event at a time: branch/jump mispredict, trap, mret, fence.i or fence.time.
- Sequences the required side effects in order: store-queue drain, I-cache invalidate, then a one-cycle pipeline flush with redirect PC.
- Back-pressures further commits while a sequence is in progress.

Parameters:
- XLEN, 32, width of PCs and targets.
- DRAIN_TIMEOUT, 64, cycles allowed in DRAIN before the sticky drain_err is raised.
- CNT_W, 16, width of the optional performance counters.

Ports:
- clock  input  1  clock.
- reset  input  1  asynchronous active-low reset; asserted when 0.
- cm_valid  input  1  ROB head commits a redirect-class event this cycle.
- cm_kind  input  3  event kind: 1=BRMISS, 2=TRAP, 3=MRET, 4=FENCE_I, 5=FENCE_TIME; 0, 6 and 7 are ignored.
- cm_target  input  XLEN  redirect PC (npc, trap vector or mepc).
- cm_ready  output  1  sequencer can accept an event (state==IDLE).
- sq_empty  input  1  store queue fully drained.
- ic_inv_req  output  1  I-cache invalidate-all request, level.
- ic_inv_ack  input  1  I-cache invalidate done, one-cycle pulse.
- flush_pipeline  output  1  one-cycle flush of frontend/IQU/EXU.
- fence_time  output  1  one-cycle fence.time pulse, coincident with flush.
- redirect_valid  output  1  one-cycle redirect strobe.
- redirect_pc  output  XLEN  redirect target, valid with redirect_valid.
- busy  output  1  state!=IDLE.
- drain_err  output  1  sticky drain-timeout flag.

Behaviour:
- Reset asserted, at any time including mid-sequence: state=IDLE, drain counter=0, latched target=0, drain_err=0, performance counters=0. All outputs are 0 except cm_ready=1.
- Accept: cm_valid && cm_ready && cm_kind in 1..5. The sequencer latches cm_kind and cm_target on that edge. Otherwise the inputs are ignored, including while busy; the ROB must hold commits while cm_ready=0.
- States: IDLE, DRAIN, INV, FLUSH.
- IDLE transitions:
  - BRMISS, TRAP or MRET -> FLUSH.
  - FENCE_I or FENCE_TIME -> DRAIN.
- DRAIN:
  - Counter increments each cycle, saturating at DRAIN_TIMEOUT.
  - When sq_empty=1: FENCE_I -> INV, FENCE_TIME -> FLUSH; the counter clears.
  - When the counter reaches DRAIN_TIMEOUT-1 without sq_empty: drain_err<=1 (sticky) and the block keeps waiting.
  - sq_empty already 1 on the first DRAIN cycle: leave after exactly 1 cycle.
- INV:
  - ic_inv_req=1 for every cycle spent in INV.
  - On ic_inv_ack=1 -> FLUSH; ic_inv_req drops on the next cycle.
  - An ack already high on the first INV cycle is honoured: INV lasts 1 cycle.
  - ic_inv_ack outside INV is ignored.
- FLUSH:
  - Lasts exactly 1 cycle: flush_pipeline=1, redirect_valid=1, redirect_pc=latched target.
  - fence_time=1 only if the latched kind is FENCE_TIME.
  - Always returns to IDLE; cm_ready=1 the following cycle.
- Latency from accept edge to flush cycle:
  - BRMISS, TRAP, MRET: 1 cycle.
  - FENCE_TIME: 2 cycles minimum.
  - FENCE_I: 3 cycles minimum.
- Outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs. cm_ready and busy are complements.
- redirect_pc holds the last latched target outside FLUSH.

Optional Feature:
- YSYX_REDIRECT_PERF_EN defined:
  - Adds output perf_brmiss, CNT_W bits.
  - Adds output perf_fence, CNT_W bits.
  - Adds output perf_drain_cycles, CNT_W bits.
  - perf_brmiss increments on each accepted BRMISS.
  - perf_fence increments on each accepted FENCE_I or FENCE_TIME.
  - perf_drain_cycles increments each cycle spent in DRAIN.
  - All three wrap modulo 2^CNT_W and clear on reset.
- YSYX_REDIRECT_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- BRMISS, cm_target=0x8000_0100, accepted at cycle 0 -> cycle 1: flush_pipeline=1, redirect_valid=1, redirect_pc=0x8000_0100, fence_time=0; cycle 2: cm_ready=1.
- FENCE_I with sq_empty=0 for 3 cycles then 1, ic_inv_ack 2 cycles after INV entry -> DRAIN lasts 4 cycles; ic_inv_req high 3 cycles; then single flush plus redirect; drain_err=0.
- FENCE_TIME with sq_empty=1 throughout -> one DRAIN cycle, then flush with fence_time=1 and redirect_valid=1 in the same cycle; ic_inv_req never asserted.
- sq_empty held 0 for 70 cycles during FENCE_TIME, DRAIN_TIMEOUT=64 -> drain_err rises at DRAIN cycle 64 and stays 1 after the flush completes.
- cm_valid=1 with kind TRAP while in INV, and cm_kind=0 in IDLE -> both ignored; no extra flush; the latched target is unchanged.
- reset pulled low mid-INV with ic_inv_req=1 -> all outputs 0 immediately (asynchronous), cm_ready=1 after release; with YSYX_REDIRECT_PERF_EN, counters read 0.
